// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The controller side uses modport master; the datapath or test side uses modport slave.
interface multicycle_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       bne;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output iord, memread, memwrite, irwrite, pcwrite, branch, bne, pcsrc, aluop,
               alusrca, alusrcb, regdst, memtoreg, regwrite, illegal, state
    );

    modport slave (
        output op, mem_ready,
        input  iord, memread, memwrite, irwrite, pcwrite, branch, bne, pcsrc, aluop,
               alusrca, alusrcb, regdst, memtoreg, regwrite, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing MIPS instructions over 3-5 cycles on a shared datapath.
// Define MC_BNE_EN to decode op 6'b000101 into the BNE state.
module multicycle_control #(
    parameter logic [5:0] OP_LW   = 6'b100011,
    parameter logic [5:0] OP_SW   = 6'b101011,
    parameter logic [5:0] OP_R    = 6'b000000,
    parameter logic [5:0] OP_BEQ  = 6'b000100,
    parameter logic [5:0] OP_ADDI = 6'b001000,
    parameter logic [5:0] OP_J    = 6'b000010
) (
    input logic                   clk,
    input logic                   rst_n,
    multicycle_control_if.master  bus
);

`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;
`endif

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBeq    = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11,
        StBne    = 4'd12
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFetch;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = StFetch;
        bus.iord     = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.pcwrite  = 1'b0;
        bus.branch   = 1'b0;
        bus.bne      = 1'b0;
        bus.pcsrc    = 2'b00;
        bus.aluop    = 2'b00;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.illegal  = 1'b0;

        case (state_q)
            StFetch: begin
                bus.memread = 1'b1;
                bus.alusrcb = 2'b01;
                // IR load and PC+4 commit only once the fetch actually returns
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
                state_d     = bus.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExec;
                    OP_BEQ:       state_d = StBeq;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = StBne;
`endif
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = (bus.op == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
                state_d     = bus.mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            StMemWr: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
                state_d      = bus.mem_ready ? StFetch : StMemWr;
            end
            StExec: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
                state_d     = StAluWb;
            end
            StAluWb: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            StBeq: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.branch  = 1'b1;
            end
            StAddiEx: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.aluop   = 2'b11;
                state_d     = StAddiWb;
            end
            StAddiWb: begin
                bus.regwrite = 1'b1;
            end
            StJump: begin
                bus.pcwrite = 1'b1;
                bus.pcsrc   = 2'b10;
            end
`ifdef MC_BNE_EN
            StBne: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.bne     = 1'b1;
            end
`endif
            // Unused codes fall back to fetch
            default: state_d = StFetch;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the controller outputs.
module tb_multicycle_control;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BNEO = 6'b000101;
    localparam logic [5:0] BAD  = 6'b111111;

    // {state}_{iord memread memwrite irwrite pcwrite branch bne}_{pcsrc}_{aluop}
    // _{alusrca}_{alusrcb}_{regdst memtoreg regwrite illegal}
    localparam logic [21:0] E_FETCH_RDY  = 22'b0000_0101100_00_00_0_01_0000;
    localparam logic [21:0] E_FETCH_WAIT = 22'b0000_0100000_00_00_0_01_0000;
    localparam logic [21:0] E_DECODE     = 22'b0001_0000000_00_00_0_11_0000;
    localparam logic [21:0] E_DEC_ILL    = 22'b0001_0000000_00_00_0_11_0001;
    localparam logic [21:0] E_MEMADR     = 22'b0010_0000000_00_00_1_10_0000;
    localparam logic [21:0] E_MEMRD      = 22'b0011_1100000_00_00_0_00_0000;
    localparam logic [21:0] E_MEMWB      = 22'b0100_0000000_00_00_0_00_0110;
    localparam logic [21:0] E_MEMWR      = 22'b0101_1010000_00_00_0_00_0000;
    localparam logic [21:0] E_EXEC       = 22'b0110_0000000_00_10_1_00_0000;
    localparam logic [21:0] E_ALUWB      = 22'b0111_0000000_00_00_0_00_1010;
    localparam logic [21:0] E_BEQ        = 22'b1000_0000010_01_01_1_00_0000;
    localparam logic [21:0] E_ADDIEX     = 22'b1001_0000000_00_11_1_10_0000;
    localparam logic [21:0] E_ADDIWB     = 22'b1010_0000000_00_00_0_00_0010;
    localparam logic [21:0] E_JUMP       = 22'b1011_0000100_10_00_0_00_0000;
`ifdef MC_BNE_EN
    localparam logic [21:0] E_BNE        = 22'b1100_0000001_01_01_1_00_0000;
`endif

    typedef struct {
        logic [21:0] v;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] actual();
        return {bus.state, bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.pcwrite,
                bus.branch, bus.bne, bus.pcsrc, bus.aluop, bus.alusrca, bus.alusrcb,
                bus.regdst, bus.memtoreg, bus.regwrite, bus.illegal};
    endfunction

    // Drive inputs for this cycle, record the expected outputs, advance one edge.
    task automatic cyc(input logic [5:0] o, input logic mr, input logic [21:0] e,
                       input string name);
        exp_t x;
        bus.op        = o;
        bus.mem_ready = mr;
        x.v           = e;
        x.name        = name;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        x;
        logic [21:0] a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                a = actual();
                n_cmp++;
                if (a !== x.v) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b", x.name, a, x.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin : stim
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.op        = RT;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(RT, 1'b0, E_FETCH_WAIT, "reset_hold");
        rst_n = 1'b1;

        // Abort an R-type in EXEC with an asynchronous reset
        cyc(RT, 1'b1, E_FETCH_RDY, "pre_rst_fetch");
        cyc(RT, 1'b1, E_DECODE, "pre_rst_decode");
        cyc(RT, 1'b1, E_EXEC, "pre_rst_exec");
        rst_n = 1'b0;
        cyc(RT, 1'b1, E_FETCH_RDY, "rst_mid_aborted");
        cyc(RT, 1'b0, E_FETCH_WAIT, "rst_mid_hold");
        rst_n = 1'b1;
        cyc(RT, 1'b0, E_FETCH_WAIT, "post_rst_wait");

        // R-type: 0,1,6,7
        cyc(RT, 1'b1, E_FETCH_RDY, "r_fetch");
        cyc(RT, 1'b1, E_DECODE, "r_decode");
        cyc(RT, 1'b1, E_EXEC, "r_exec");
        cyc(RT, 1'b1, E_ALUWB, "r_aluwb");

        // LW with two-cycle read stall: 0,1,2,3,3,3,4
        cyc(LW, 1'b1, E_FETCH_RDY, "lw_fetch");
        cyc(LW, 1'b1, E_DECODE, "lw_decode");
        cyc(LW, 1'b1, E_MEMADR, "lw_memadr");
        cyc(LW, 1'b0, E_MEMRD, "lw_memrd_stall1");
        cyc(LW, 1'b0, E_MEMRD, "lw_memrd_stall2");
        cyc(LW, 1'b1, E_MEMRD, "lw_memrd_ready");
        cyc(LW, 1'b1, E_MEMWB, "lw_memwb");

        // SW with three-cycle fetch stall and one write wait
        cyc(SW, 1'b0, E_FETCH_WAIT, "sw_fetch_stall1");
        cyc(SW, 1'b0, E_FETCH_WAIT, "sw_fetch_stall2");
        cyc(SW, 1'b0, E_FETCH_WAIT, "sw_fetch_stall3");
        cyc(SW, 1'b1, E_FETCH_RDY, "sw_fetch_ready");
        cyc(SW, 1'b1, E_DECODE, "sw_decode");
        cyc(SW, 1'b1, E_MEMADR, "sw_memadr");
        cyc(SW, 1'b0, E_MEMWR, "sw_memwr_wait");
        cyc(SW, 1'b1, E_MEMWR, "sw_memwr_ready");

        // BEQ: 0,1,8
        cyc(BEQ, 1'b1, E_FETCH_RDY, "beq_fetch");
        cyc(BEQ, 1'b1, E_DECODE, "beq_decode");
        cyc(BEQ, 1'b1, E_BEQ, "beq_exec");

        // J: 0,1,11
        cyc(JMP, 1'b1, E_FETCH_RDY, "j_fetch");
        cyc(JMP, 1'b1, E_DECODE, "j_decode");
        cyc(JMP, 1'b1, E_JUMP, "j_jump");

        // ADDI: 0,1,9,10
        cyc(ADDI, 1'b1, E_FETCH_RDY, "addi_fetch");
        cyc(ADDI, 1'b1, E_DECODE, "addi_decode");
        cyc(ADDI, 1'b1, E_ADDIEX, "addi_ex");
        cyc(ADDI, 1'b1, E_ADDIWB, "addi_wb");

        // Unknown opcode: single illegal pulse, back to fetch with no writes
        cyc(BAD, 1'b1, E_FETCH_RDY, "ill_fetch");
        cyc(BAD, 1'b1, E_DEC_ILL, "ill_decode");
        cyc(BAD, 1'b0, E_FETCH_WAIT, "ill_back_to_fetch");

        // Op 000101: BNE when the feature is built in, illegal otherwise
        cyc(BNEO, 1'b1, E_FETCH_RDY, "bne_fetch");
`ifdef MC_BNE_EN
        cyc(BNEO, 1'b1, E_DECODE, "bne_decode");
        cyc(BNEO, 1'b1, E_BNE, "bne_exec");
`else
        cyc(BNEO, 1'b1, E_DEC_ILL, "bne_decode_illegal");
`endif
        cyc(BNEO, 1'b0, E_FETCH_WAIT, "bne_back_to_fetch");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle successor to the single-cycle main decoder. It is a Moore FSM that sequences each MIPS instruction over 3–5 cycles: fetch, decode, then execute/memory/writeback. It drives the shared-datapath controls (IR write, PC write, mux selects, ALU op) and waits on a memory-ready handshake. Opcodes are parameters, so the decoder can be retargeted without RTL edits.

Parameters:
OP_LW, 6'b100011, load-word opcode
OP_SW, 6'b101011, store-word opcode
OP_R, 6'b000000, R-type opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  opcode from instruction register; sampled only in DECODE
mem_ready  in  1  memory access completes this cycle
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memread  out  1  memory read request
memwrite  out  1  memory write request
irwrite  out  1  load instruction register
pcwrite  out  1  unconditional PC write
branch  out  1  PC write if ALU zero
bne  out  1  PC write if ALU not zero (optional feature)
pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
aluop  out  2  00 add, 01 sub, 10 funct, 11 addi
alusrca  out  1  ALU A: 0 = PC, 1 = register A
alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
regdst  out  1  destination register: 1 = rd, 0 = rt
memtoreg  out  1  write-back data: 1 = MDR, 0 = ALUOut
regwrite  out  1  register file write
illegal  out  1  one-cycle pulse on an unknown opcode
state  out  4  current state, for debug

Behaviour:
- State register resets asynchronously to FETCH (4'd0) when rst_n = 0. Reset mid-instruction aborts it; no partial writes follow deassertion.
- All outputs are decoded combinationally from the state, except the mem_ready-qualified strobes noted below. Every output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12. Codes 13–15 are unused and return to FETCH on the next edge.
- FETCH:
  - Drives memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite are asserted only while mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state by op: LW/SW → MEMADR, R → EXEC, BEQ → BEQ, ADDI → ADDIEX, J → JUMP.
  - Any other op: pulse illegal=1 in this cycle, then → FETCH. No register or memory write occurs.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD for LW, MEMWR for SW (op is held stable by the IR).
- MEMRD: memread=1, iord=1. Holds until mem_ready=1, then → MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. → FETCH.
- MEMWR:
  - Drives memwrite=1, iord=1; holds until mem_ready=1, then → FETCH.
  - memwrite stays high for the whole wait.
- EXEC: alusrca=1, alusrcb=00, aluop=10. → ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. → FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=11. → ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. → FETCH.
- JUMP: pcwrite=1, pcsrc=10. → FETCH.
- Latency with mem_ready held at 1: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3.
- Each memory stall adds one cycle per cycle of mem_ready=0.

Optional Feature:
MC_BNE_EN
- Defined: op 6'b000101 in DECODE → BNE state. BNE drives alusrca=1, alusrcb=00, aluop=01, pcsrc=01, bne=1, then → FETCH.
- Undefined: the bne port exists but is tied to 0. Op 000101 is treated as illegal, and state 12 is unreachable.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC, release → state=0, all outputs 0 except the FETCH set; pcwrite=0 while mem_ready=0.
- R-type, mem_ready=1, op=000000 → state sequence 0,1,6,7,0; regwrite=1 and regdst=1 only in cycle 4.
- LW with 2-cycle read stall: op=100011, mem_ready low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0; memread=1 and iord=1 throughout MEMRD.
- SW with FETCH stall: mem_ready=0 for 3 cycles in FETCH → irwrite=0 and pcwrite=0 during the stall, both 1 in the ready cycle. Then 1,2,5,0, with memwrite=1 only in state 5.
- BEQ/J/ADDI: op=000100 → 0,1,8,0 with branch=1, pcsrc=01, aluop=01. op=000010 → 0,1,11,0 with pcwrite=1, pcsrc=10. op=001000 → 0,1,9,10,0 with aluop=11, then regwrite=1.
- Illegal/BNE: op=111111 → illegal=1 for exactly 1 cycle in DECODE, then state 0 with no writes. op=000101 → illegal when MC_BNE_EN is undefined; → 0,1,12,0 with bne=1 when it is defined.
